// File: rtl/set_bit_scanner_pkg.sv
// Shared types for the set-bit scanner.
// Holds the two-state control encoding used by the top.
package set_bit_scanner_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scanner_state_e;

endpackage

// File: rtl/set_bit_scanner_lod.sv
// Leading-one detector: index of the highest set bit.
// An all-zero vector reports index 0.
module leading_one_detect #(
   parameter int DATA_WD = 8,
   parameter int IND_WD  = $clog2(DATA_WD)
) (
   input  logic [DATA_WD-1:0] vec,
   output logic [IND_WD-1:0]  index
);

   // Ascending scan: the last hit wins, so the MSB-most one is kept.
   always_comb begin
      index = '0;
      for (int i = 0; i < DATA_WD; i++) begin
         if (vec[i]) begin
            index = IND_WD'(i);
         end
      end
   end

endmodule

// File: rtl/set_bit_scanner.sv
// Accepts a vector, then emits each set-bit index MSB first,
// one beat per output handshake, with a per-vector beat number.
module set_bit_scanner
   import set_bit_scanner_pkg::*;
#(
   parameter int DATA_WD = 8,
   parameter int IND_WD  = $clog2(DATA_WD),
   parameter int SEQ_WD  = $clog2(DATA_WD + 1)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [DATA_WD-1:0] i_data,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [IND_WD-1:0]  o_index,
   output logic [SEQ_WD-1:0]  o_seq,
   output logic               o_last
);

   scanner_state_e     state_q;
   logic [DATA_WD-1:0] rem_q;
   logic [SEQ_WD-1:0]  seq_q;
   logic [DATA_WD-1:0] rem_clr;
   logic               single;

   leading_one_detect #(
      .DATA_WD (DATA_WD),
      .IND_WD  (IND_WD)
   ) u_lod (
      .vec   (rem_q),
      .index (o_index)
   );

   assign single  = (rem_q != '0) &&
                    ((rem_q & (rem_q - DATA_WD'(1))) == '0);
   assign rem_clr = rem_q & ~(DATA_WD'(1) << o_index);

   assign o_ready = (state_q == IDLE);
   assign o_valid = (state_q == SCAN);
   assign o_last  = single;
   assign o_seq   = seq_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         seq_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (i_valid) begin
                  rem_q <= i_data;
                  seq_q <= '0;
                  if (i_data != '0) begin
                     state_q <= SCAN;
                  end
               end
            end
            SCAN: begin
               if (i_ready) begin
                  rem_q <= rem_clr;
                  // Park the counter at 0 so it never exceeds DATA_WD-1.
                  if (single) begin
                     state_q <= IDLE;
                     seq_q   <= '0;
                  end else begin
                     seq_q <= seq_q + SEQ_WD'(1);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_set_bit_scanner.sv
// Bench for set_bit_scanner: directed cases then random vectors,
// checked against a queue of expected set-bit indices.
module tb_set_bit_scanner;

   localparam int DATA_WD = 8;
   localparam int IND_WD  = 3;
   localparam int SEQ_WD  = 4;

   logic               i_clk = 1'b0;
   logic               i_rst = 1'b1;
   logic               i_valid = 1'b0;
   logic               o_ready;
   logic [DATA_WD-1:0] i_data = '0;
   logic               o_valid;
   logic               i_ready = 1'b0;
   logic [IND_WD-1:0]  o_index;
   logic [SEQ_WD-1:0]  o_seq;
   logic               o_last;

   int checks = 0;
   int errors = 0;

   set_bit_scanner #(.DATA_WD(DATA_WD)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_data  (i_data),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_index (o_index),
      .o_seq   (o_seq),
      .o_last  (o_last)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, int'(o_valid), 0);
      chk({tag, "_ready"}, int'(o_ready), 1);
   endtask

   // Inputs driven and outputs sampled on the falling edge.
   task automatic run_vec(input logic [7:0] v, input int stall_pct,
                          input bit junk, input int stall_beat,
                          input int stall_cycles);
      int exp_idx[$];
      int k;
      int held;
      int guard;
      bit rdy;
      for (int b = DATA_WD - 1; b >= 0; b--) begin
         if (v[b]) exp_idx.push_back(b);
      end
      chk("accept_ready", int'(o_ready), 1);
      i_valid = 1'b1;
      i_data  = v;
      @(negedge i_clk);
      if (v == 8'h00) begin
         i_valid = 1'b0;
         i_data  = '0;
         chk_idle("zero_vec");
         @(negedge i_clk);
         chk_idle("zero_vec2");
         return;
      end
      i_valid = junk;
      i_data  = junk ? 8'hFF : 8'h00;
      k = 0;
      held = 0;
      guard = 0;
      while (k < exp_idx.size()) begin
         chk("beat_valid", int'(o_valid), 1);
         chk("beat_ready", int'(o_ready), 0);
         chk("beat_index", int'(o_index), exp_idx[k]);
         chk("beat_seq", int'(o_seq), k);
         chk("beat_last", int'(o_last), int'(k == exp_idx.size() - 1));
         if (k == stall_beat && held < stall_cycles) begin
            rdy = 1'b0;
            held++;
         end else if (stall_beat >= 0) begin
            rdy = 1'b1;
         end else begin
            rdy = ($urandom_range(0, 99) >= stall_pct);
         end
         i_ready = rdy;
         @(negedge i_clk);
         if (rdy) k++;
         guard++;
         if (guard > 300) begin
            chk("beat_timeout", 1, 0);
            break;
         end
      end
      i_valid = 1'b0;
      i_data  = '0;
      i_ready = 1'b0;
      chk_idle("after_last");
   endtask

   initial begin
      repeat (2) @(negedge i_clk);
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_ready", int'(o_ready), 1);
      chk("rst_index", int'(o_index), 0);
      chk("rst_seq", int'(o_seq), 0);
      chk("rst_last", int'(o_last), 0);
      i_rst = 1'b0;
      @(negedge i_clk);

      run_vec(8'b1010_0100, 0, 1'b0, 99, 0);
      run_vec(8'h00, 0, 1'b0, -1, 0);
      run_vec(8'b1010_0100, 0, 1'b0, 1, 3);
      run_vec(8'hFF, 0, 1'b0, 99, 0);

      // Reset in the middle of a scan discards the rest of 8'hC0.
      i_valid = 1'b1;
      i_data  = 8'hC0;
      @(negedge i_clk);
      i_valid = 1'b0;
      i_data  = '0;
      chk("rst_mid_b0", int'(o_index), 7);
      i_ready = 1'b1;
      @(negedge i_clk);
      chk("rst_mid_b1", int'(o_index), 6);
      chk("rst_mid_seq", int'(o_seq), 1);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst   = 1'b0;
      i_ready = 1'b0;
      chk_idle("rst_mid");
      chk("rst_mid_seq0", int'(o_seq), 0);
      chk("rst_mid_last", int'(o_last), 0);
      run_vec(8'h01, 0, 1'b0, 99, 0);

      run_vec(8'h81, 0, 1'b1, 99, 0);

      for (int n = 0; n < 60; n++) begin
         run_vec(8'($urandom_range(0, 255)), 35,
                 bit'($urandom_range(0, 1)), -1, 0);
      end
      run_vec(8'h00, 0, 1'b0, -1, 0);
      run_vec(8'h80, 50, 1'b1, -1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
